// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU flag types, flag bit positions and output-stage occupancy states
//
// Purpose : definitions shared by the ALU result stage, the flag calculator
//           and any branch-condition logic that consumes {N,Z,C,V}.
// Contents: alu_flags_t     - per-result flag bundle {n,z,c,v}
//           FLAG_N..FLAG_V  - bit positions of each flag in a 4-bit vector
//           occ_state_e     - occupancy of the two-entry output buffer
//           flags_to_vec    - packs alu_flags_t into the {N,Z,C,V} vector

package alu_pkg;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // EMPTY: nothing held; ONE: main register valid; FULL: main and skid valid.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_e;

  // Places each flag at its named bit position rather than relying on
  // struct member order, so the vector layout survives struct edits.
  function automatic logic [3:0] flags_to_vec(input alu_flags_t f);
    logic [3:0] vec;
    vec         = 4'b0000;
    vec[FLAG_N] = f.n;
    vec[FLAG_Z] = f.z;
    vec[FLAG_C] = f.c;
    vec[FLAG_V] = f.v;
    return vec;
  endfunction

endpackage

// File: rtl/alu_flag_calc.sv
// rtl/alu_flag_calc.sv - combinational N/Z/C/V derivation from an ALU result
//
// Purpose : derives the condition flags of one ALU result. Purely
//           combinational so it can also feed branch-condition evaluation.
// Ports   : result   [WIDTH-1:0] in  - selected ALU result
//           carry               in  - adder carry-out
//           overflow            in  - adder signed overflow
//           flags   alu_flags_t out - {n,z,c,v}

module alu_flag_calc
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] result,
  input  logic             carry,
  input  logic             overflow,
  output alu_flags_t       flags
);

  always_comb begin
    flags   = '0;
    flags.n = result[WIDTH-1];
    flags.z = (result == '0);
    flags.c = carry;
    flags.v = overflow;
  end

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - registered ALU output stage with skid buffer and architectural flags
//
// Purpose : captures the ALU result with its derived flags and hands it to the
//           consumer over valid/ready. A main register drives the outputs and a
//           skid register absorbs one extra entry so the upstream can run at
//           full rate while in_ready stays a pure register output.
// Ports   : clk, reset_n            - clock, asynchronous active-low reset
//           in_valid / in_ready     - upstream handshake (in_ready registered)
//           in_result, in_carry,
//           in_overflow, in_set_flags - ALU result and qualifiers
//           out_valid / out_ready   - downstream handshake
//           out_result, out_flags   - delivered entry and its {N,Z,C,V}
//           flags_q                 - architectural {N,Z,C,V}

module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_carry,
  input  logic             in_overflow,
  input  logic             in_set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic [3:0]       flags_q
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    alu_flags_t       flags;
    logic             set_flags;
  } entry_t;

  occ_state_e state_q;
  entry_t     main_q;
  entry_t     skid_q;
  entry_t     new_entry;
  alu_flags_t new_flags;
  logic       out_valid_q;
  logic       in_ready_q;
  logic [3:0] flags_arch_q;
  logic       accept;
  logic       deliver;

  alu_flag_calc #(
    .WIDTH(WIDTH)
  ) u_flag_calc (
    .result  (in_result),
    .carry   (in_carry),
    .overflow(in_overflow),
    .flags   (new_flags)
  );

  always_comb begin
    new_entry           = '0;
    new_entry.result    = in_result;
    new_entry.flags     = new_flags;
    new_entry.set_flags = in_set_flags;
  end

  // in_ready_q is only low in FULL, so accept never fires there.
  assign accept  = in_valid && in_ready_q;
  assign deliver = out_valid_q && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= OCC_EMPTY;
      main_q       <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      flags_arch_q <= 4'b0000;
    end else begin
      // The entry in main is the one being delivered in every state.
      if (deliver && main_q.set_flags) begin
        flags_arch_q <= flags_to_vec(main_q.flags);
      end

      case (state_q)
        OCC_EMPTY: begin
          if (accept) begin
            main_q      <= new_entry;
            out_valid_q <= 1'b1;
            state_q     <= OCC_ONE;
          end
        end

        OCC_ONE: begin
          if (accept && deliver) begin
            main_q <= new_entry;
          end else if (accept) begin
            // Main is stalled; park the newcomer so main stays stable.
            skid_q     <= new_entry;
            in_ready_q <= 1'b0;
            state_q    <= OCC_FULL;
          end else if (deliver) begin
            out_valid_q <= 1'b0;
            state_q     <= OCC_EMPTY;
          end
        end

        OCC_FULL: begin
          if (deliver) begin
            main_q     <= skid_q;
            in_ready_q <= 1'b1;
            state_q    <= OCC_ONE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= OCC_EMPTY;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = main_q.result;
  assign out_flags  = flags_to_vec(main_q.flags);
  assign flags_q    = flags_arch_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - scoreboard bench for alu_result_stage

module tb_alu_result_stage;

  localparam int W = 64;

  logic         clk;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_result;
  logic         in_carry;
  logic         in_overflow;
  logic         in_set_flags;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic [3:0]   out_flags;
  logic [3:0]   flags_q;

  alu_result_stage #(
    .WIDTH(W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_result   (in_result),
    .in_carry    (in_carry),
    .in_overflow (in_overflow),
    .in_set_flags(in_set_flags),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_flags   (out_flags),
    .flags_q     (flags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic [3:0]   f;
    logic         sf;
  } exp_t;

  exp_t       q[$];
  logic [3:0] exp_fq;
  int         nvec;
  int         nfail;
  int         ndeliv;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_flags(input logic [W-1:0] r, input logic c, input logic v);
    logic n;
    logic z;
    n = ($signed(r) < 0);
    z = (r == 0);
    return {n, z, c, v};
  endfunction

  // Monitor: the queue holds exactly the entries the stage should be holding,
  // so its size predicts out_valid and in_ready directly.
  always @(negedge clk) begin
    exp_t e;
    bit   acc;
    if (!reset_n) begin
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_flags_q", {60'd0, flags_q}, 64'd0);
      chk("rst_out_result", out_result, 64'd0);
      chk("rst_out_flags", {60'd0, out_flags}, 64'd0);
      q.delete();
      exp_fq = 4'b0000;
    end else begin
      chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
      chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
      chk("flags_q", {60'd0, flags_q}, {60'd0, exp_fq});
      acc = in_valid && (q.size() < 2);
      if (q.size() > 0) begin
        chk("out_result", out_result, q[0].r);
        chk("out_flags", {60'd0, out_flags}, {60'd0, q[0].f});
        if (out_ready) begin
          if (q[0].sf) exp_fq = q[0].f;
          void'(q.pop_front());
          ndeliv++;
        end
      end
      if (acc) begin
        e.r  = in_result;
        e.f  = model_flags(in_result, in_carry, in_overflow);
        e.sf = in_set_flags;
        q.push_back(e);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] r, input logic c, input logic o, input logic sf);
    in_valid     = v;
    in_result    = r;
    in_carry     = c;
    in_overflow  = o;
    in_set_flags = sf;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    cycle();
    cycle();
    reset_n = 1'b1;
  endtask

  initial begin
    int d0;
    nvec   = 0;
    nfail  = 0;
    ndeliv = 0;
    exp_fq = 4'b0000;
    reset_n   = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    cycle();
    do_reset();

    // Single accept of a zero result with carry: Z and C set.
    out_ready = 1'b1;
    drive(1'b1, 64'd0, 1'b1, 1'b0, 1'b1);
    cycle();
    in_valid = 1'b0;
    chk("single_valid", {63'd0, out_valid}, 64'd1);
    chk("single_result", out_result, 64'd0);
    chk("single_flags", {60'd0, out_flags}, 64'h6);
    cycle();
    chk("single_flags_q", {60'd0, flags_q}, 64'h6);
    cycle();

    // Streaming 1..8 at full rate.
    d0 = ndeliv;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, W'(i), 1'b0, 1'b0, 1'b0);
      chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    chk("stream_count", 64'(ndeliv - d0), 64'd8);
    cycle();

    // Fill to FULL under backpressure, then drain.
    out_ready = 1'b0;
    drive(1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 64'h5, 1'b0, 1'b0, 1'b0);
    cycle();
    in_valid = 1'b0;
    chk("full_in_ready", {63'd0, in_ready}, 64'd0);
    chk("full_flags", {60'd0, out_flags}, 64'h8);
    chk("full_result", out_result, 64'h8000_0000_0000_0000);
    cycle();
    chk("stall_result", out_result, 64'h8000_0000_0000_0000);
    out_ready = 1'b1;
    cycle();
    chk("drain1_result", out_result, 64'h5);
    chk("drain1_in_ready", {63'd0, in_ready}, 64'd1);
    cycle();
    chk("drain2_valid", {63'd0, out_valid}, 64'd0);

    // Non-flag-setting delivery must leave flags_q alone.
    drive(1'b1, 64'd0, 1'b0, 1'b0, 1'b1);
    cycle();
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
    cycle();
    in_valid = 1'b0;
    chk("hold_out_flags", {60'd0, out_flags}, 64'h8);
    cycle();
    chk("hold_flags_q", {60'd0, flags_q}, 64'h4);
    cycle();

    // Reset while FULL.
    out_ready = 1'b0;
    drive(1'b1, 64'h1234, 1'b1, 1'b1, 1'b1);
    cycle();
    drive(1'b1, 64'h5678, 1'b0, 1'b1, 1'b1);
    cycle();
    in_valid = 1'b0;
    chk("pre_rst_in_ready", {63'd0, in_ready}, 64'd0);
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("async_rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("async_rst_flags_q", {60'd0, flags_q}, 64'd0);
    cycle();
    reset_n = 1'b1;
    cycle();
    chk("post_rst_valid", {63'd0, out_valid}, 64'd0);

    // Random traffic; inputs are randomised even when in_valid is low.
    for (int i = 0; i < 10000; i++) begin
      logic [W-1:0] r;
      case ($urandom_range(0, 3))
        0:       r = '0;
        1:       r = {1'b1, 31'($urandom), 32'($urandom)};
        default: r = {32'($urandom), 32'($urandom)};
      endcase
      drive($urandom_range(0, 3) != 0, r, 1'($urandom), 1'($urandom), 1'($urandom));
      out_ready = 1'($urandom);
      cycle();
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() > 0; i++) cycle();
    cycle();
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
